adc_scan_scheduler: RTL and testbench

- Owns the MCP3008 8-channel 10-bit SPI ADC (mode 0; pins AD_CLK/CS/DIN/DOUT) and sequences every conversion frame on it.
- Shares the ADC between two requesters:
  - a background scanner that cycles through a channel mask;
  - an on-demand request port, used for fast current sampling.
- Latches every single-ended result into an 8-entry sample bank for the motor/CAN logic.
- Replaces free-running bit-banged ADC sequencing in the motor top.

---
 rtl/mcp3008_pkg.sv | 38 +++
 rtl/mcp3008_frame_engine.sv | 127 ++++++++++++
 rtl/adc_scan_scheduler.sv | 136 +++++++++++++
 tb/tb_adc_scan_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 scan scheduler and its frame engine.
package mcp3008_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } state_e;

  typedef enum logic {
    SRC_SCAN,
    SRC_REQ
  } src_e;

  localparam int unsigned NUM_CH         = 8;
  localparam int unsigned FRAME_BITS     = 17;
  localparam int unsigned FIRST_DATA_BIT = 8;

  // Round-robin walk from ptr+1 upward; the ptr itself comes last, which covers the wrap case.
  function automatic logic [2:0] next_scan_ch(input logic [NUM_CH-1:0] mask,
                                              input logic [2:0]        ptr);
    logic [2:0] sel;
    logic [2:0] cand;
    logic       found;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = ptr + 3'(i);
      if (!found && mask[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mcp3008_frame_engine.sv
// Runs one 17-period SPI mode-0 frame on the MCP3008: start bit, sgl/diff, channel, 10 data bits.
module mcp3008_frame_engine
  import mcp3008_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned CS_GAP  = 25
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [2:0] ch_i,
  input  logic       sgl_i,
  input  logic       dout_i,
  output logic       done_o,
  output logic [9:0] result_o,
  output logic       idle_o,
  output logic       ad_clk_o,
  output logic       cs_o,
  output logic       din_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS);
  localparam logic [4:0] DATA_BIT = 5'(FIRST_DATA_BIT);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [4:0] bit_q, bit_d;
  logic       low_q, low_d;
  logic [2:0] ch_q, ch_d;
  logic       sgl_q, sgl_d;
  logic [9:0] res_q, res_d;
  logic       div_end;
  logic       last_fall;

  function automatic logic cmd_bit(input logic [4:0] idx, input logic sgl, input logic [2:0] ch);
    case (idx)
      5'd1:    return 1'b1;
      5'd2:    return sgl;
      5'd3:    return ch[2];
      5'd4:    return ch[1];
      5'd5:    return ch[0];
      default: return 1'b0;
    endcase
  endfunction

  assign div_end   = (div_q == ((state_q == ST_GAP) ? GAP_LAST : DIV_LAST));
  assign last_fall = (state_q == ST_SHIFT) && low_q && div_end && (bit_q == LAST_BIT);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      low_q   <= 1'b0;
      ch_q    <= '0;
      sgl_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      low_q   <= low_d;
      ch_q    <= ch_d;
      sgl_q   <= sgl_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    low_d   = low_q;
    ch_d    = ch_q;
    sgl_d   = sgl_q;
    res_d   = res_q;
    if (state_q == ST_IDLE) begin
      div_d = '0;
      if (start_i) begin
        state_d = ST_SETUP;
        ch_d    = ch_i;
        sgl_d   = sgl_i;
      end
    end else begin
      div_d = div_end ? '0 : div_q + 8'd1;
      case (state_q)
        ST_SETUP: if (div_end) begin
          state_d = ST_SHIFT;
          bit_d   = 5'd1;
          low_d   = 1'b0;
        end
        ST_SHIFT: begin
          // DOUT is taken on the first clk of each high half in the data periods.
          if (!low_q && (div_q == '0) && (bit_q >= DATA_BIT))
            res_d = {res_q[8:0], dout_i};
          if (div_end) begin
            if (!low_q) begin
              low_d = 1'b1;
            end else begin
              low_d = 1'b0;
              bit_d = bit_q + 5'd1;
              if (bit_q == LAST_BIT) state_d = ST_GAP;
            end
          end
        end
        ST_GAP: if (div_end) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ad_clk_o = (state_q == ST_SHIFT) && !low_q;
    cs_o     = !((state_q == ST_SETUP) || (state_q == ST_SHIFT));
    din_o    = 1'b0;
    if (state_q == ST_SETUP)
      din_o = cmd_bit(5'd1, sgl_q, ch_q);
    else if (state_q == ST_SHIFT)
      din_o = cmd_bit(low_q ? bit_q + 5'd1 : bit_q, sgl_q, ch_q);
    done_o   = last_fall;
    idle_o   = (state_q == ST_IDLE);
    result_o = res_q;
  end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Shares the MCP3008 between a background channel scanner and an on-demand request port.
module adc_scan_scheduler
  import mcp3008_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned CS_GAP  = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic [7:0]  scan_mask,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_ch,
  input  logic        req_sgl,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ch,
  output logic [9:0]  rsp_data,
  output logic [79:0] sample_data,
  output logic [7:0]  sample_valid,
  output logic        busy,
  output logic        AD_CLK,
  output logic        CS,
  output logic        DIN,
  input  logic        DOUT
);

  logic        idle, done;
  logic [9:0]  result;
  logic        grant_req, grant_scan;
  logic [2:0]  scan_ch;

  src_e        last_q, last_d, src_q, src_d;
  logic [2:0]  ptr_q, ptr_d, cur_ch_q, cur_ch_d;
  logic        cur_sgl_q, cur_sgl_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [2:0]  rsp_ch_q, rsp_ch_d;
  logic [9:0]  rsp_data_q, rsp_data_d;
  logic [79:0] bank_q, bank_d;
  logic [7:0]  valid_q, valid_d;

  assign scan_ch    = next_scan_ch(scan_mask, ptr_q);
  assign grant_req  = rst_n && idle && req_valid &&
                      (!(scan_en && (scan_mask != '0)) || (last_q == SRC_SCAN));
  assign grant_scan = rst_n && idle && scan_en && (scan_mask != '0) && !grant_req;

  mcp3008_frame_engine #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) u_engine (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (grant_req || grant_scan),
    .ch_i     (grant_req ? req_ch : scan_ch),
    .sgl_i    (grant_req ? req_sgl : 1'b1),
    .dout_i   (DOUT),
    .done_o   (done),
    .result_o (result),
    .idle_o   (idle),
    .ad_clk_o (AD_CLK),
    .cs_o     (CS),
    .din_o    (DIN)
  );

  always_comb begin
    last_d      = last_q;
    src_d       = src_q;
    ptr_d       = ptr_q;
    cur_ch_d    = cur_ch_q;
    cur_sgl_d   = cur_sgl_q;
    rsp_valid_d = 1'b0;
    rsp_ch_d    = rsp_ch_q;
    rsp_data_d  = rsp_data_q;
    bank_d      = bank_q;
    valid_d     = valid_q;
    if (grant_req) begin
      last_d    = SRC_REQ;
      src_d     = SRC_REQ;
      cur_ch_d  = req_ch;
      cur_sgl_d = req_sgl;
    end else if (grant_scan) begin
      last_d    = SRC_SCAN;
      src_d     = SRC_SCAN;
      ptr_d     = scan_ch;
      cur_ch_d  = scan_ch;
      cur_sgl_d = 1'b1;
    end
    // done fires on the last SHIFT cycle, so publishing lands on the GAP entry edge.
    if (done) begin
      if (cur_sgl_q) begin
        bank_d[int'(cur_ch_q)*10 +: 10] = result;
        valid_d[cur_ch_q]               = 1'b1;
      end
      if (src_q == SRC_REQ) begin
        rsp_valid_d = 1'b1;
        rsp_ch_d    = cur_ch_q;
        rsp_data_d  = result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= SRC_SCAN;
      src_q       <= SRC_SCAN;
      ptr_q       <= 3'd7;
      cur_ch_q    <= '0;
      cur_sgl_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_data_q  <= '0;
      bank_q      <= '0;
      valid_q     <= '0;
    end else begin
      last_q      <= last_d;
      src_q       <= src_d;
      ptr_q       <= ptr_d;
      cur_ch_q    <= cur_ch_d;
      cur_sgl_q   <= cur_sgl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ch_q    <= rsp_ch_d;
      rsp_data_q  <= rsp_data_d;
      bank_q      <= bank_d;
      valid_q     <= valid_d;
    end
  end

  assign req_ready    = grant_req;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_ch       = rsp_ch_q;
  assign rsp_data     = rsp_data_q;
  assign sample_data  = bank_q;
  assign sample_valid = valid_q;
  assign busy         = !idle;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a behavioural MCP3008 model on the SPI pins.
module tb_adc_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic [7:0]  scan_mask;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_ch;
  logic        req_sgl;
  logic        rsp_valid;
  logic [2:0]  rsp_ch;
  logic [9:0]  rsp_data;
  logic [79:0] sample_data;
  logic [7:0]  sample_valid;
  logic        busy;
  logic        AD_CLK, CS, DIN;
  logic        DOUT = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  adc_scan_scheduler #(
    .CLK_DIV (2),
    .CS_GAP  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_en      (scan_en),
    .scan_mask    (scan_mask),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_ch       (req_ch),
    .req_sgl      (req_sgl),
    .rsp_valid    (rsp_valid),
    .rsp_ch       (rsp_ch),
    .rsp_data     (rsp_data),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .busy         (busy),
    .AD_CLK       (AD_CLK),
    .CS           (CS),
    .DIN          (DIN),
    .DOUT         (DOUT)
  );

  always #5 clk = ~clk;

  // ADC model: command captured on rises 1..5, B9..B0 presented after falls 7..16.
  logic [4:0] m_cmd = '0;
  logic [9:0] m_val = '0;
  int         m_rise = 0;
  int         m_fall = 0;
  logic [4:0] fr_cmd[$];

  always @(posedge AD_CLK or negedge AD_CLK or posedge CS) begin
    if (CS === 1'b1) begin
      if (m_rise > 0) fr_cmd.push_back(m_cmd);
      m_rise = 0;
      m_fall = 0;
      m_cmd  = '0;
      DOUT   = 1'b0;
    end else if (AD_CLK === 1'b1) begin
      m_rise++;
      if (m_rise <= 5) begin
        m_cmd = {m_cmd[3:0], DIN};
        if (m_rise == 5) m_val = m_cmd[3] ? 10'h100 + 10'(m_cmd[2:0]) : 10'h3FF;
      end
    end else begin
      m_fall++;
      if (m_fall >= 7 && m_fall <= 16) DOUT = m_val[16-m_fall];
      else DOUT = 1'b0;
    end
  end

  int rsp_cnt = 0;
  always @(posedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (fr_cmd.size() < target && n < budget) begin
      step();
      n++;
    end
    if (fr_cmd.size() < target) check("frame_timeout", 80'(fr_cmd.size()), 80'(target));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", {79'd0, busy}, 80'd0);
  endtask

  task automatic issue_req(input logic [2:0] ch, input logic sgl, output int lat);
    req_ch    = ch;
    req_sgl   = sgl;
    req_valid = 1'b1;
    #1;
    check("req_ready_idle", {79'd0, req_ready}, 80'd1);
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      step();
      req_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  logic [79:0] exp_bank;
  task automatic set_exp(input int ch, input logic [9:0] v);
    exp_bank[ch*10 +: 10] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lat, rdy, rdy_busy, rc, bz;
    exp_bank  = '0;
    rst_n     = 1'b0;
    scan_en   = 1'b0;
    scan_mask = 8'h00;
    req_valid = 1'b0;
    req_ch    = 3'd0;
    req_sgl   = 1'b0;
    repeat (3) step();
    check("rst_cs", {79'd0, CS}, 80'd1);
    check("rst_adclk", {79'd0, AD_CLK}, 80'd0);
    check("rst_din", {79'd0, DIN}, 80'd0);
    check("rst_busy", {79'd0, busy}, 80'd0);
    check("rst_ready", {79'd0, req_ready}, 80'd0);
    check("rst_rsp", {66'd0, rsp_valid, rsp_ch, rsp_data}, 80'd0);
    check("rst_bank", sample_data, 80'd0);
    check("rst_valid", {72'd0, sample_valid}, 80'd0);

    // Background scan over mask 0x25 starting from pointer 7.
    scan_en   = 1'b1;
    scan_mask = 8'h25;
    rst_n     = 1'b1;
    base = fr_cmd.size();
    wait_frames(base + 3, 400);
    set_exp(0, 10'h100);
    set_exp(2, 10'h102);
    set_exp(5, 10'h105);
    check("scan_valid3", {72'd0, sample_valid}, 80'h25);
    check("scan_ch2_data", {70'd0, sample_data[29:20]}, 80'h102);
    check("scan_bank", sample_data, exp_bank);
    if (fr_cmd.size() >= base + 3) begin
      check("scan_f0_cmd", {75'd0, fr_cmd[base]}, 80'b11000);
      check("scan_f1_din", {75'd0, fr_cmd[base+1]}, 80'b11010);
      check("scan_f2_cmd", {75'd0, fr_cmd[base+2]}, 80'b11101);
    end
    wait_frames(base + 4, 200);
    if (fr_cmd.size() >= base + 4) check("scan_f3_cmd", {75'd0, fr_cmd[base+3]}, 80'b11000);
    scan_en = 1'b0;
    wait_idle(200);

    // On-demand single-ended ch6 from idle.
    issue_req(3'd6, 1'b1, lat);
    check("req6_latency", 80'(lat), 80'd71);
    check("req6_rsp_ch", {77'd0, rsp_ch}, 80'd6);
    check("req6_rsp_data", {70'd0, rsp_data}, 80'h106);
    set_exp(6, 10'h106);
    check("req6_valid", {72'd0, sample_valid}, 80'h65);
    step();
    check("req6_pulse", {79'd0, rsp_valid}, 80'd0);
    wait_idle(200);

    // Differential ch1 must leave the bank alone.
    issue_req(3'd1, 1'b0, lat);
    check("diff_latency", 80'(lat), 80'd71);
    check("diff_rsp", {67'd0, rsp_ch, rsp_data}, {67'd0, 3'd1, 10'h3FF});
    check("diff_valid", {72'd0, sample_valid}, 80'h65);
    check("diff_bank", sample_data, exp_bank);
    wait_idle(200);

    // Contention: last grant was REQ, so SCAN goes first, then strict alternation.
    base      = fr_cmd.size();
    scan_mask = 8'h10;
    scan_en   = 1'b1;
    req_ch    = 3'd3;
    req_sgl   = 1'b1;
    req_valid = 1'b1;
    rdy = 0;
    rdy_busy = 0;
    for (int n = 0; n < 600 && fr_cmd.size() < base + 4; n++) begin
      step();
      if (req_ready === 1'b1) rdy++;
      if (req_ready === 1'b1 && busy === 1'b1) rdy_busy++;
    end
    req_valid = 1'b0;
    scan_en   = 1'b0;
    if (fr_cmd.size() < base + 4) check("alt_timeout", 80'(fr_cmd.size()), 80'(base + 4));
    else begin
      check("alt_f0", {75'd0, fr_cmd[base]},   80'b11100);
      check("alt_f1", {75'd0, fr_cmd[base+1]}, 80'b11011);
      check("alt_f2", {75'd0, fr_cmd[base+2]}, 80'b11100);
      check("alt_f3", {75'd0, fr_cmd[base+3]}, 80'b11011);
    end
    check("alt_ready_cnt", 80'(rdy), 80'd2);
    check("alt_ready_busy", 80'(rdy_busy), 80'd0);
    wait_idle(200);
    set_exp(3, 10'h103);
    set_exp(4, 10'h104);
    check("alt_rsp", {67'd0, rsp_ch, rsp_data}, {67'd0, 3'd3, 10'h103});
    check("alt_valid", {72'd0, sample_valid}, 80'h7D);
    check("alt_bank", sample_data, exp_bank);

    // Reset during SHIFT period 10 of an on-demand ch7 frame.
    req_ch    = 3'd7;
    req_sgl   = 1'b1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int n = 0; n < 200 && m_rise < 10; n++) step();
    check("mid_rise", 80'(m_rise), 80'd10);
    rc    = rsp_cnt;
    rst_n = 1'b0;
    step();
    check("mid_cs", {79'd0, CS}, 80'd1);
    check("mid_adclk", {79'd0, AD_CLK}, 80'd0);
    check("mid_valid", {72'd0, sample_valid}, 80'd0);
    check("mid_busy", {79'd0, busy}, 80'd0);
    rst_n = 1'b1;
    repeat (100) step();
    check("mid_no_rsp", 80'(rsp_cnt - rc), 80'd0);

    // Mask swap mid-frame takes effect at the next selection; empty mask stays idle.
    exp_bank  = '0;
    base      = fr_cmd.size();
    scan_mask = 8'h01;
    scan_en   = 1'b1;
    repeat (20) step();
    scan_mask = 8'h80;
    wait_frames(base + 2, 300);
    scan_mask = 8'h00;
    if (fr_cmd.size() >= base + 2) begin
      check("mask_f0", {75'd0, fr_cmd[base]},   80'b11000);
      check("mask_f1", {75'd0, fr_cmd[base+1]}, 80'b11111);
    end
    wait_idle(200);
    bz = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (busy !== 1'b0) bz++;
    end
    check("mask0_busy", 80'(bz), 80'd0);
    set_exp(0, 10'h100);
    set_exp(7, 10'h107);
    check("mask_valid", {72'd0, sample_valid}, 80'h81);
    check("mask_bank", sample_data, exp_bank);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
